// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared encodings for the WISC-SP20 pipeline control slice
package pipe_ctrl_pkg;

  localparam int REG_W = 3;

  localparam logic [1:0] RUN_ENC   = 2'd0;
  localparam logic [1:0] REDIR_ENC = 2'd1;
  localparam logic [1:0] DWAIT_ENC = 2'd2;
  localparam logic [1:0] HALT_ENC  = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN   = RUN_ENC,
    ST_REDIR = REDIR_ENC,
    ST_DWAIT = DWAIT_ENC,
    ST_HALT  = HALT_ENC
  } state_e;

  // Instruction word loaded into IF/ID and ID/EX when they are flushed.
  localparam logic [15:0] NOP = 16'h0800;

endpackage

// File: rtl/dff.sv
// rtl/dff.sv - generic flop cell with asynchronous active-high reset
module dff #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) q_o <= RST_VAL;
    else       q_o <= d_i;
  end

endmodule

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - load-use compare between the ID sources and the EX load destination
module hazard_detect #(
  parameter int REG_W = pipe_ctrl_pkg::REG_W
) (
  input  logic [REG_W-1:0] id_rs_i,
  input  logic             id_rs_vld_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_rt_vld_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic             ex_is_load_i,
  output logic             load_use_o
);

  assign load_use_o = ex_is_load_i &
                      ((id_rs_vld_i & (id_rs_i == ex_rd_i)) |
                       (id_rt_vld_i & (id_rt_i == ex_rd_i)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush/bubble/freeze control with a saturating stall counter
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = pipe_ctrl_pkg::REG_W,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic             id_rs_vld_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_rt_vld_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic             ex_is_load_i,
  input  logic             ex_redirect_i,
  input  logic             imem_stall_i,
  input  logic             dmem_stall_i,
  input  logic             mem_halt_i,
  output logic             stall_pc_o,
  output logic             stall_decode_o,
  output logic             flush_fetch_o,
  output logic             bubble_ex_o,
  output logic             freeze_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  state_e           state_d, state_q, eff_state;
  logic [1:0]       state_raw;
  logic             pend_d, pend_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             load_use;

  hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
    .id_rs_i     (id_rs_i),
    .id_rs_vld_i (id_rs_vld_i),
    .id_rt_i     (id_rt_i),
    .id_rt_vld_i (id_rt_vld_i),
    .ex_rd_i     (ex_rd_i),
    .ex_is_load_i(ex_is_load_i),
    .load_use_o  (load_use)
  );

  dff #(.W(2))     u_state_ff (.clk_i(clk_i), .rst_i(rst_i), .d_i(state_d), .q_o(state_raw));
  dff #(.W(1))     u_pend_ff  (.clk_i(clk_i), .rst_i(rst_i), .d_i(pend_d),  .q_o(pend_q));
  dff #(.W(CNT_W)) u_cnt_ff   (.clk_i(clk_i), .rst_i(rst_i), .d_i(cnt_d),   .q_o(cnt_q));

  assign state_q = state_e'(state_raw);

  // Leaving DWAIT behaves as the state it exits into, so a held redirect acts this cycle.
  always_comb begin
    eff_state = state_q;
    if (state_q == ST_DWAIT && !dmem_stall_i) eff_state = pend_q ? ST_REDIR : ST_RUN;
  end

  always_comb begin
    stall_pc_o     = 1'b0;
    stall_decode_o = 1'b0;
    flush_fetch_o  = 1'b0;
    bubble_ex_o    = 1'b0;
    freeze_o       = 1'b0;
    halted_o       = 1'b0;
    state_d        = ST_RUN;
    pend_d         = 1'b0;
    if (state_q == ST_HALT || mem_halt_i) begin
      stall_pc_o     = 1'b1;
      stall_decode_o = 1'b1;
      freeze_o       = 1'b1;
      halted_o       = 1'b1;
      state_d        = ST_HALT;
    end else if (dmem_stall_i) begin
      stall_pc_o     = 1'b1;
      stall_decode_o = 1'b1;
      freeze_o       = 1'b1;
      state_d        = ST_DWAIT;
      pend_d         = pend_q | ex_redirect_i | (state_q == ST_REDIR);
    end else if (ex_redirect_i) begin
      flush_fetch_o  = 1'b1;
      bubble_ex_o    = 1'b1;
      state_d        = imem_stall_i ? ST_REDIR : ST_RUN;
    end else if (eff_state == ST_REDIR) begin
      flush_fetch_o  = 1'b1;
      stall_pc_o     = imem_stall_i;
      state_d        = imem_stall_i ? ST_REDIR : ST_RUN;
    end else if (imem_stall_i) begin
      stall_pc_o     = 1'b1;
      flush_fetch_o  = 1'b1;
    end else if (load_use) begin
      stall_pc_o     = 1'b1;
      stall_decode_o = 1'b1;
      bubble_ex_o    = 1'b1;
    end
    if (flush_fetch_o) stall_decode_o = 1'b0;
  end

  assign cnt_d       = (stall_pc_o && cnt_q != {CNT_W{1'b1}}) ? cnt_q + 1'b1 : cnt_q;
  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl with a rule-level model
module tb_pipe_hazard_ctrl;

  localparam int RW    = 3;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  typedef struct packed {
    logic [RW-1:0] rs; logic rsv; logic [RW-1:0] rt; logic rtv;
    logic [RW-1:0] rd; logic ld; logic redir; logic imem; logic dmem; logic halt;
  } stim_t;

  typedef struct packed {
    logic [5:0]    ctl;   // {stall_pc, stall_decode, flush_fetch, bubble_ex, freeze, halted}
    logic [CW-1:0] cnt;
    logic [15:0]   tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  stim_t s;
  logic stall_pc, stall_decode, flush_fetch, bubble_ex, freeze, halted;
  logic [CW-1:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t sb_q[$];

  // Model state: plain flags for "halted", "waiting on data memory", "waiting on refetch".
  bit m_halt, m_dwait, m_redir, m_pend;
  int m_cnt;
  int tag_ctr = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_W(RW), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst),
    .id_rs_i(s.rs), .id_rs_vld_i(s.rsv), .id_rt_i(s.rt), .id_rt_vld_i(s.rtv),
    .ex_rd_i(s.rd), .ex_is_load_i(s.ld), .ex_redirect_i(s.redir),
    .imem_stall_i(s.imem), .dmem_stall_i(s.dmem), .mem_halt_i(s.halt),
    .stall_pc_o(stall_pc), .stall_decode_o(stall_decode), .flush_fetch_o(flush_fetch),
    .bubble_ex_o(bubble_ex), .freeze_o(freeze), .halted_o(halted), .stall_cnt_o(stall_cnt)
  );

  function automatic logic [5:0] act_ctl();
    return {stall_pc, stall_decode, flush_fetch, bubble_ex, freeze, halted};
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_halt = 0; m_dwait = 0; m_redir = 0; m_pend = 0; m_cnt = 0;
  endtask

  // Evaluate one cycle from the behavioural rules, return expectation, advance the model.
  task automatic model_step(input stim_t st, output exp_t e);
    bit pc, dec, fl, bub, frz, hl, lu, refetch;
    pc = 0; dec = 0; fl = 0; bub = 0; frz = 0; hl = 0;
    lu = st.ld && ((st.rsv && st.rs == st.rd) || (st.rtv && st.rt == st.rd));
    e.cnt = CW'(m_cnt);
    if (m_halt || st.halt) begin
      pc = 1; dec = 1; frz = 1; hl = 1;
      m_halt = 1;
    end else if (st.dmem) begin
      pc = 1; dec = 1; frz = 1;
      m_pend  = m_pend || st.redir || m_redir;
      m_dwait = 1; m_redir = 0;
    end else begin
      refetch = m_redir || (m_dwait && m_pend);
      m_dwait = 0; m_pend = 0;
      if (st.redir) begin
        fl = 1; bub = 1; m_redir = st.imem;
      end else if (refetch) begin
        fl = 1; pc = st.imem; m_redir = st.imem;
      end else if (st.imem) begin
        pc = 1; fl = 1; m_redir = 0;
      end else if (lu) begin
        pc = 1; dec = 1; bub = 1; m_redir = 0;
      end else begin
        m_redir = 0;
      end
    end
    if (pc && m_cnt < CMAX) m_cnt++;
    e.ctl = {pc, dec, fl, bub, frz, hl};
    e.tag = 16'(tag_ctr++);
  endtask

  task automatic step(input stim_t st);
    exp_t e;
    rst = 1'b0;
    s = st;
    model_step(st, e);
    sb_q.push_back(e);
    @(posedge clk); #1;
  endtask

  function automatic stim_t mk(input int rs, input bit rsv, input int rt, input bit rtv,
                               input int rd, input bit ld, input bit redir, input bit imem,
                               input bit dmem, input bit halt);
    stim_t t;
    t.rs = RW'(rs); t.rsv = rsv; t.rt = RW'(rt); t.rtv = rtv; t.rd = RW'(rd);
    t.ld = ld; t.redir = redir; t.imem = imem; t.dmem = dmem; t.halt = halt;
    return t;
  endfunction

  // Asynchronous reset asserted mid-cycle: outputs must clear without waiting for an edge.
  task automatic async_reset();
    @(negedge clk); #2;
    s = '0;
    rst = 1'b1;
    #1;
    check("async_reset_ctl", int'(act_ctl()), 0);
    check("async_reset_cnt", int'(stall_cnt), 0);
    model_reset();
    @(posedge clk); #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check($sformatf("ctl[%0d]", e.tag), int'(act_ctl()), int'(e.ctl));
        check($sformatf("cnt[%0d]", e.tag), int'(stall_cnt), int'(e.cnt));
      end
    end
  end

  initial begin : driver
    stim_t idle, r;
    idle = '0;
    s = '0;
    model_reset();
    #3;
    check("reset_ctl", int'(act_ctl()), 0);
    check("reset_cnt", int'(stall_cnt), 0);
    @(posedge clk); #1;
    step(idle);
    step(mk(3, 1, 2, 1, 3, 1, 0, 0, 0, 0));   // load-use on rs
    step(idle);
    step(mk(3, 0, 5, 1, 3, 1, 0, 0, 0, 0));   // rs invalid, rt differs
    step(mk(1, 1, 3, 1, 3, 1, 0, 0, 0, 0));   // load-use on rt
    step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));   // redirect, imem ready
    step(idle);
    step(mk(3, 1, 2, 1, 3, 1, 1, 0, 0, 0));   // redirect squashes load-use
    step(idle);
    step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));   // redirect then imem busy 3 cycles
    for (int i = 0; i < 3; i++) step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    step(idle);
    step(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0));   // redirect with imem busy -> REDIR state
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    step(mk(3, 1, 2, 1, 3, 1, 0, 0, 0, 0));   // REDIR exit cycle
    step(idle);
    for (int i = 1; i <= 4; i++) step(mk(0, 0, 0, 0, 0, 0, i == 2, 0, 1, 0));
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));   // pending redirect acts, imem busy
    step(idle);
    step(idle);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));   // HALT in MEM
    for (int i = 0; i < 3; i++) step(idle);
    async_reset();
    for (int i = 0; i < 20; i++) step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    step(idle);
    async_reset();
    for (int n = 0; n < 600; n++) begin
      r.rd    = RW'($urandom_range(0, 7));
      r.rs    = ($urandom_range(0, 1) != 0) ? r.rd : RW'($urandom_range(0, 7));
      r.rt    = ($urandom_range(0, 2) == 0) ? r.rd : RW'($urandom_range(0, 7));
      r.rsv   = $urandom_range(0, 3) != 0;
      r.rtv   = $urandom_range(0, 1) != 0;
      r.ld    = $urandom_range(0, 2) == 0;
      r.redir = $urandom_range(0, 6) == 0;
      r.imem  = $urandom_range(0, 4) == 0;
      r.dmem  = $urandom_range(0, 6) == 0;
      r.halt  = $urandom_range(0, 99) == 0;
      if (m_halt && $urandom_range(0, 4) == 0) async_reset();
      else step(r);
    end
    step(idle);
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
